// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: runs one req/ack transaction per load/store and
// freezes the pipeline through MemStall_o until the access is finished.
//
// state | meaning
// IDLE  | waiting for a load/store from EX/MEM; stalls combinationally on access
// REQ   | request outstanding, waiting for mem_ack_i or the timeout
// DONE  | one-cycle completion slot; EX/MEM advances at its end, inputs ignored
module mem_access_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic        MemStall_o,
    output logic [31:0] ReadData_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        misalign_o,
    output logic        timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             access;
    logic             aligned;

    assign access     = MemRead_i | MemWrite_i;
    assign aligned    = (Addr_i[1:0] == 2'b00);
    assign MemStall_o = ((state == IDLE) && access) || (state == REQ);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            ReadData_o  <= '0;
            misalign_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && aligned) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= {Addr_i[31:2], 2'b00};
                        mem_wdata_o <= WriteData_i;
                        wait_cnt    <= CNT_W'(TIMEOUT - 1);
                        state       <= REQ;
                    end else if (access) begin
                        // A simultaneous read+write counts as a write, so it keeps ReadData_o.
                        misalign_o <= 1'b1;
                        if (!MemWrite_i) ReadData_o <= '0;
                        state <= DONE;
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack in the terminal-count cycle completes normally.
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        if (!mem_we_o) ReadData_o <= mem_rdata_i;
                        state <= DONE;
                    end else if (wait_cnt == '0) begin
                        mem_req_o <= 1'b0;
                        timeout_o <= 1'b1;
                        if (!mem_we_o) ReadData_o <= '0;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random loads/stores checked per
// transaction against cycle counts and data derived from the access rules.
module tb_mem_access_ctrl;
    localparam int TIMEOUT = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] Addr_i, WriteData_i;
    logic        MemStall_o;
    logic [31:0] ReadData_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        misalign_o, timeout_o;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rd_exp = '0;
    logic        to_exp = 1'b0;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Addr_i(Addr_i), .WriteData_i(WriteData_i),
        .MemStall_o(MemStall_o), .ReadData_o(ReadData_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One instruction in MEM: k = REQ cycle (0-based) in which ack is given; k >= TIMEOUT means never.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int k, input logic [31:0] rdata);
        int          stalls = 0;
        int          reqs = 0;
        int          exp_stalls;
        int          exp_reqs;
        logic        acc, mis, is_rd;
        logic        done_seen = 1'b0;
        logic [31:0] rd_prev;
        acc     = rd | wr;
        mis     = acc && (addr[1:0] != 2'b00);
        is_rd   = rd && !wr;
        rd_prev = rd_exp;
        if (!acc) begin
            exp_stalls = 0; exp_reqs = 0;
        end else if (mis) begin
            exp_stalls = 1; exp_reqs = 0;
            if (is_rd) rd_exp = '0;
        end else if (k < TIMEOUT) begin
            exp_stalls = 2 + k; exp_reqs = k + 1;
            if (is_rd) rd_exp = rdata;
        end else begin
            exp_stalls = 1 + TIMEOUT; exp_reqs = TIMEOUT;
            to_exp = 1'b1;
            if (is_rd) rd_exp = '0;
        end

        @(negedge clk_i);
        MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; WriteData_i = wdata;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            #1;
            if (mem_req_o) begin
                check("req_addr", mem_addr_o, {addr[31:2], 2'b00});
                check("req_we", {31'b0, mem_we_o}, {31'b0, wr});
                check("req_wdata", mem_wdata_o, wdata);
                mem_ack_i   = (reqs == k);
                mem_rdata_i = (reqs == k) ? rdata : $urandom;
                reqs++;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
            end
            if (MemStall_o) begin
                stalls++;
                check("misalign_quiet", {31'b0, misalign_o}, 32'd0);
                check("rdata_held", ReadData_o, rd_prev);
                @(negedge clk_i);
            end else begin
                done_seen = 1'b1;
            end
        end
        if (!done_seen) check("cycle_budget", 32'd0, 32'd1);
        check("stall_cycles", stalls, exp_stalls);
        check("req_cycles", reqs, exp_reqs);
        check("done_req_low", {31'b0, mem_req_o}, 32'd0);
        check("read_data", ReadData_o, rd_exp);
        check("misalign", {31'b0, misalign_o}, {31'b0, mis});
        check("timeout", {31'b0, timeout_o}, {31'b0, to_exp});
    endtask

    task automatic random_access();
        int          sel;
        logic        rd, wr;
        logic [31:0] addr;
        int          k;
        sel  = $urandom_range(0, 7);
        rd   = (sel == 1 || sel == 2 || sel == 3 || sel == 7);
        wr   = (sel == 4 || sel == 5 || sel == 6 || sel == 7);
        addr = $urandom;
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        k = ($urandom_range(0, 3) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2)
                                        : $urandom_range(0, 4);
        do_access(rd, wr, addr, $urandom, k, $urandom);
    endtask

    initial begin
        rst_i = 1'b1;
        MemRead_i = 1'b0; MemWrite_i = 1'b0; Addr_i = '0; WriteData_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_we", {31'b0, mem_we_o}, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_rdata", ReadData_o, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        check("rst_timeout", {31'b0, timeout_o}, 32'd0);
        check("rst_stall_idle", {31'b0, MemStall_o}, 32'd0);
        MemRead_i = 1'b1;
        #1;
        check("rst_stall_access", {31'b0, MemStall_o}, 32'd1);
        MemRead_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        do_access(1'b1, 1'b0, 32'h0000_0104, 32'h0, 3, 32'hDEAD_BEEF);
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 0, 32'hFFFF_0000);
        do_access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 0, 32'h1234_5678);
        do_access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h5555_5555);
        do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);
        do_access(1'b1, 1'b1, 32'h0000_0043, 32'h0, 0, 32'h0);
        do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 100, 32'h0);
        do_access(1'b0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 2, 32'h0);
        do_access(1'b0, 1'b0, 32'h0000_0008, 32'h0, 0, 32'h0);
        for (int i = 0; i < 60; i++) random_access();

        // Reset two cycles into REQ, then a stray ack.
        @(negedge clk_i);
        MemRead_i = 1'b1; MemWrite_i = 1'b0; Addr_i = 32'h0000_0040; mem_ack_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("req_before_rst", {31'b0, mem_req_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_async_req", {31'b0, mem_req_o}, 32'd0);
        check("rst_async_rdata", ReadData_o, 32'd0);
        check("rst_async_timeout", {31'b0, timeout_o}, 32'd0);
        check("rst_async_addr", mem_addr_o, 32'd0);
        check("rst_async_stall", {31'b0, MemStall_o}, 32'd1);
        MemRead_i = 1'b0;
        rd_exp = '0; to_exp = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check("stray_ack_req", {31'b0, mem_req_o}, 32'd0);
        check("stray_ack_rdata", ReadData_o, 32'd0);
        check("stray_ack_stall", {31'b0, MemStall_o}, 32'd0);

        for (int i = 0; i < 20; i++) random_access();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
